// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: ALU opcode encodings, the arbiter FSM state type
// and the default datapath width.
package riscv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SUB   = 5'd1;
   localparam logic [4:0] ALU_SLL   = 5'd2;
   localparam logic [4:0] ALU_SLT   = 5'd3;
   localparam logic [4:0] ALU_SLTU  = 5'd4;
   localparam logic [4:0] ALU_XOR   = 5'd5;
   localparam logic [4:0] ALU_SRL   = 5'd6;
   localparam logic [4:0] ALU_SRA   = 5'd7;
   localparam logic [4:0] ALU_OR    = 5'd8;
   localparam logic [4:0] ALU_AND   = 5'd9;
   localparam logic [4:0] ALU_LUI   = 5'd10;
   localparam logic [4:0] ALU_AUIPC = 5'd11;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } alu_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found scanning
// upward from last+1, wrapping modulo N. Grant is one-hot or zero.
module rr_arbiter #(
   parameter int N = 2,
   localparam int LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic [N-1:0]  grant
);

   logic [N-1:0] mask;
   logic [N-1:0] req_masked;

   // Requesters strictly above the previous winner get first pick.
   for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = (LW'(gi) > last);
   end

   assign req_masked = req & mask;

   // x & -x isolates the lowest set bit; fall back to the unmasked set on wrap.
   always_comb begin
      grant = '0;
      if (|req_masked) grant = req_masked & (-req_masked);
      else             grant = req & (-req);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin
// arbitration and a registered, valid/ready result returned to the winner.
module alu_arbiter
   import riscv_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = XLEN_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*XLEN-1:0] req_pc,
   input  logic [NUM_REQ*XLEN-1:0] req_imm,
   input  logic [NUM_REQ*XLEN-1:0] req_rs1_val,
   input  logic [NUM_REQ*XLEN-1:0] req_rs2_val,
   input  logic [NUM_REQ*5-1:0]    req_alu_control,
   output logic [NUM_REQ-1:0]      rsp_valid,
   input  logic [NUM_REQ-1:0]      rsp_ready,
   output logic                    rsp_rd_write_control,
   output logic [XLEN-1:0]         rsp_rd_write_val,
   output logic [XLEN-1:0]         alu_pc,
   output logic [XLEN-1:0]         alu_imm,
   output logic [XLEN-1:0]         alu_rs1_val,
   output logic [XLEN-1:0]         alu_rs2_val,
   output logic [4:0]              alu_control,
   input  logic                    alu_rd_write_control,
   input  logic [XLEN-1:0]         alu_rd_write_val
);

   localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   alu_arb_state_t     state_reg;
   logic [LW-1:0]      own_reg;
   logic [LW-1:0]      last_grant_reg;
   logic [NUM_REQ-1:0] grant;
   logic [LW-1:0]      grant_idx;
   logic               can_accept;
   logic               accept;

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .req   (req_valid),
      .last  (last_grant_reg),
      .grant (grant)
   );

   // The owner draining its result in the same cycle frees the slot for a new op.
   assign can_accept = (state_reg == IDLE) | ((state_reg == RESP) & rsp_ready[own_reg]);
   assign req_ready  = grant & {NUM_REQ{can_accept & (|req_valid)}};
   assign accept     = |req_ready;

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) grant_idx = LW'(i);
      end
   end

   // req_ready is zero without an accept, so the ALU drive collapses to 0.
   always_comb begin
      alu_pc      = '0;
      alu_imm     = '0;
      alu_rs1_val = '0;
      alu_rs2_val = '0;
      alu_control = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            alu_pc      = req_pc[i*XLEN +: XLEN];
            alu_imm     = req_imm[i*XLEN +: XLEN];
            alu_rs1_val = req_rs1_val[i*XLEN +: XLEN];
            alu_rs2_val = req_rs2_val[i*XLEN +: XLEN];
            alu_control = req_alu_control[i*5 +: 5];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg            <= IDLE;
         own_reg              <= '0;
         last_grant_reg       <= LW'(NUM_REQ - 1);
         rsp_valid            <= '0;
         rsp_rd_write_control <= 1'b0;
         rsp_rd_write_val     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  state_reg            <= RESP;
                  own_reg              <= grant_idx;
                  last_grant_reg       <= grant_idx;
                  rsp_valid            <= req_ready;
                  rsp_rd_write_control <= alu_rd_write_control;
                  rsp_rd_write_val     <= alu_rd_write_val;
               end
            end
            RESP: begin
               if (accept) begin
                  own_reg              <= grant_idx;
                  last_grant_reg       <= grant_idx;
                  rsp_valid            <= req_ready;
                  rsp_rd_write_control <= alu_rd_write_control;
                  rsp_rd_write_val     <= alu_rd_write_val;
               end else if (rsp_ready[own_reg]) begin
                  state_reg <= IDLE;
                  rsp_valid <= '0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and a behavioural RV32 ALU.
module tb_alu_arbiter;
   import riscv_pkg::*;

   localparam int NR = 2;
   localparam int XL = 32;

   logic             clk;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*XL-1:0] req_pc;
   logic [NR*XL-1:0] req_imm;
   logic [NR*XL-1:0] req_rs1_val;
   logic [NR*XL-1:0] req_rs2_val;
   logic [NR*5-1:0]  req_alu_control;
   logic [NR-1:0]    rsp_valid;
   logic [NR-1:0]    rsp_ready;
   logic             rsp_rd_write_control;
   logic [XL-1:0]    rsp_rd_write_val;
   logic [XL-1:0]    alu_pc, alu_imm, alu_rs1_val, alu_rs2_val;
   logic [4:0]       alu_control;
   logic             alu_rd_write_control;
   logic [XL-1:0]    alu_rd_write_val;

   int errors = 0;
   int checks = 0;

   alu_arbiter #(.NUM_REQ(NR), .XLEN(XL)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_pc               (req_pc),
      .req_imm              (req_imm),
      .req_rs1_val          (req_rs1_val),
      .req_rs2_val          (req_rs2_val),
      .req_alu_control      (req_alu_control),
      .rsp_valid            (rsp_valid),
      .rsp_ready            (rsp_ready),
      .rsp_rd_write_control (rsp_rd_write_control),
      .rsp_rd_write_val     (rsp_rd_write_val),
      .alu_pc               (alu_pc),
      .alu_imm              (alu_imm),
      .alu_rs1_val          (alu_rs1_val),
      .alu_rs2_val          (alu_rs2_val),
      .alu_control          (alu_control),
      .alu_rd_write_control (alu_rd_write_control),
      .alu_rd_write_val     (alu_rd_write_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RV32 ALU standing in for the real instance.
   always_comb begin
      alu_rd_write_control = 1'b1;
      alu_rd_write_val     = '0;
      case (alu_control)
         ALU_ADD:   alu_rd_write_val = alu_rs1_val + alu_rs2_val;
         ALU_SUB:   alu_rd_write_val = alu_rs1_val - alu_rs2_val;
         ALU_SLL:   alu_rd_write_val = alu_rs1_val << alu_rs2_val[4:0];
         ALU_SLT:   alu_rd_write_val = {31'd0, $signed(alu_rs1_val) < $signed(alu_rs2_val)};
         ALU_SLTU:  alu_rd_write_val = {31'd0, alu_rs1_val < alu_rs2_val};
         ALU_XOR:   alu_rd_write_val = alu_rs1_val ^ alu_rs2_val;
         ALU_SRL:   alu_rd_write_val = alu_rs1_val >> alu_rs2_val[4:0];
         ALU_SRA:   alu_rd_write_val = $unsigned($signed(alu_rs1_val) >>> alu_rs2_val[4:0]);
         ALU_OR:    alu_rd_write_val = alu_rs1_val | alu_rs2_val;
         ALU_AND:   alu_rd_write_val = alu_rs1_val & alu_rs2_val;
         ALU_LUI:   alu_rd_write_val = alu_imm;
         ALU_AUIPC: alu_rd_write_val = alu_pc + alu_imm;
         default: begin
            alu_rd_write_control = 1'b0;
            alu_rd_write_val     = '0;
         end
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         $display("[%0t] %s observed=%h ok", $time, tag, obs);
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      req_alu_control[i*5 +: 5] = op;
      req_rs1_val[i*XL +: XL]   = a;
      req_rs2_val[i*XL +: XL]   = b;
      req_pc[i*XL +: XL]        = 32'h0000_1000;
      req_imm[i*XL +: XL]       = 32'h0000_0040;
   endtask

   initial begin
      rst_n           = 1'b0;
      req_valid       = '0;
      rsp_ready       = '0;
      req_pc          = '0;
      req_imm         = '0;
      req_rs1_val     = '0;
      req_rs2_val     = '0;
      req_alu_control = '0;
      #2;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_wc", 32'(rsp_rd_write_control), 32'h0);
      chk("reset_val", rsp_rd_write_val, 32'h0);
      chk("reset_req_ready", 32'(req_ready), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: single ADD from requester 0
      set_req(0, ALU_ADD, 32'd5, 32'd7);
      req_valid = 2'b01;
      #1;
      chk("t1_req_ready", 32'(req_ready), 32'h1);
      chk("t1_alu_rs1", alu_rs1_val, 32'd5);
      chk("t1_alu_ctrl", 32'(alu_control), 32'(ALU_ADD));
      tick();
      req_valid = 2'b00;
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_val", rsp_rd_write_val, 32'd12);
      chk("t1_wc", 32'(rsp_rd_write_control), 32'h1);

      // 2: both requesters every cycle, owner always ready -> alternating grants
      set_req(0, ALU_XOR, 32'h0000_00F0, 32'h0000_00FF);
      set_req(1, ALU_OR,  32'h0000_00F0, 32'h0000_000F);
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] exp_g;
         exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
         #1;
         chk($sformatf("t2_req_ready_%0d", k), 32'(req_ready), 32'(exp_g));
         tick();
         chk($sformatf("t2_rsp_valid_%0d", k), 32'(rsp_valid), 32'(exp_g));
         chk($sformatf("t2_val_%0d", k), rsp_rd_write_val,
             (exp_g == 2'b10) ? 32'h0000_00FF : 32'h0000_000F);
      end

      // 3: req1 SUB result stalled for 3 cycles
      set_req(1, ALU_SUB, 32'd3, 32'd5);
      req_valid = 2'b10;
      #1;
      chk("t3_req_ready", 32'(req_ready), 32'h2);
      tick();
      chk("t3_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("t3_val", rsp_rd_write_val, 32'hFFFF_FFFE);
      set_req(0, ALU_ADD, 32'd5, 32'd7);
      set_req(1, ALU_ADD, 32'd1, 32'd1);
      req_valid = 2'b11;
      rsp_ready = 2'b01;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("t3_stall_ready_%0d", k), 32'(req_ready), 32'h0);
         chk($sformatf("t3_stall_alu_rs1_%0d", k), alu_rs1_val, 32'h0);
         tick();
         chk($sformatf("t3_stall_valid_%0d", k), 32'(rsp_valid), 32'h2);
         chk($sformatf("t3_stall_val_%0d", k), rsp_rd_write_val, 32'hFFFF_FFFE);
      end
      rsp_ready = 2'b11;
      #1;
      chk("t3_release_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      chk("t3_release_valid", 32'(rsp_valid), 32'h1);
      chk("t3_release_val", rsp_rd_write_val, 32'd12);

      // 4: back-to-back on the same owner
      set_req(0, ALU_SLTU, 32'd1, 32'hFFFF_FFFF);
      req_valid = 2'b01;
      rsp_ready = 2'b01;
      #1;
      chk("t4_req_ready_a", 32'(req_ready), 32'h1);
      tick();
      chk("t4_rsp_valid_a", 32'(rsp_valid), 32'h1);
      chk("t4_val_a", rsp_rd_write_val, 32'd1);
      set_req(0, ALU_SRA, 32'h8000_0000, 32'd4);
      #1;
      chk("t4_req_ready_b", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      chk("t4_rsp_valid_b", 32'(rsp_valid), 32'h1);
      chk("t4_val_b", rsp_rd_write_val, 32'hF800_0000);
      tick();
      chk("t4_drain_valid", 32'(rsp_valid), 32'h0);

      // 5: unknown opcode passes through as wc=0, val=0
      set_req(1, 5'd31, 32'd9, 32'd9);
      req_valid = 2'b10;
      rsp_ready = 2'b00;
      tick();
      req_valid = 2'b00;
      chk("t5_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("t5_wc", 32'(rsp_rd_write_control), 32'h0);
      chk("t5_val", rsp_rd_write_val, 32'h0);

      // 6: asynchronous reset while holding a result, then priority back to req0
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_reset_valid", 32'(rsp_valid), 32'h0);
      tick();
      rst_n = 1'b1;
      set_req(0, ALU_ADD, 32'd2, 32'd3);
      set_req(1, ALU_ADD, 32'd4, 32'd4);
      req_valid = 2'b11;
      #1;
      chk("t6_req_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      chk("t6_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t6_val", rsp_rd_write_val, 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
